// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply / divide unit producing HI/LO.
// Multiply is a 32-step radix-2 Booth; divide is a 32-step restoring divide
// on magnitudes with a sign fix-up on exit.
// Build option: define MULTDIV_DIV_EN to compile in the divider, the DIV state
// and the div_zero flag. Without it, start_div is ignored and div_zero is 0.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

`ifdef MULTDIV_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Accumulator is 33 bits so that subtracting M = -2^31 cannot overflow.
  // In divide mode its low 32 bits hold the partial remainder.
  logic [32:0] acc_q, acc_d;
  logic [31:0] q_q, q_d;     // multiplier / quotient shift register
  logic        qm1_q, qm1_d; // Booth Q(-1) bit
  logic [31:0] m_q, m_d;     // multiplicand / divisor magnitude
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [32:0] booth_sum;
  logic [32:0] m_ext;

`ifdef MULTDIV_DIV_EN
  logic        sa_q, sa_d;   // sign of dividend
  logic        sb_q, sb_d;   // sign of divisor
  logic        dzp_q, dzp_d; // divisor was zero: finish without writing
  logic        dz_q, dz_d;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
`endif

  assign m_ext = {m_q[31], m_q};

  // Next-state, datapath step and result write-back
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    booth_sum = acc_q;
`ifdef MULTDIV_DIV_EN
    sa_d      = sa_q;
    sb_d      = sb_q;
    dzp_d     = dzp_q;
    div_shift = {acc_q[31:0], q_q[31]};
    div_diff  = div_shift[31:0] - m_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = MULT;
          cnt_d   = 6'd32;
          acc_d   = '0;
          q_d     = a;
          qm1_d   = 1'b0;
          m_d     = b;
        end
`ifdef MULTDIV_DIV_EN
        else if (start_div) begin
          // A zero divisor passes through DIV with an empty count so DONE
          // is reached one edge after the start, without touching HI/LO.
          state_d = DIV;
          sa_d    = a[31];
          sb_d    = b[31];
          acc_d   = '0;
          qm1_d   = 1'b0;
          q_d     = a[31] ? (32'd0 - a) : a;
          m_d     = b[31] ? (32'd0 - b) : b;
          if (b == 32'd0) begin
            cnt_d = 6'd0;
            dzp_d = 1'b1;
          end else begin
            cnt_d = 6'd32;
            dzp_d = 1'b0;
          end
        end
`endif
      end

      MULT: begin
        if (cnt_q != 6'd0) begin
          case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
          endcase
          acc_d = {booth_sum[32], booth_sum[32:1]};
          q_d   = {booth_sum[0], q_q[31:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q - 6'd1;
        end else begin
          hi_d    = acc_q[31:0];
          lo_d    = q_q;
          state_d = DONE;
        end
      end

`ifdef MULTDIV_DIV_EN
      DIV: begin
        if (cnt_q != 6'd0) begin
          // Restoring step: the remainder is always below the divisor, so
          // the shifted value fits in 33 bits and the kept difference in 32.
          if (div_shift >= {1'b0, m_q}) begin
            acc_d = {1'b0, div_diff};
            q_d   = {q_q[30:0], 1'b1};
          end else begin
            acc_d = {1'b0, div_shift[31:0]};
            q_d   = {q_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 6'd1;
        end else begin
          if (!dzp_q) begin
            hi_d = sa_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            lo_d = (sa_q ^ sb_q) ? (32'd0 - q_q) : q_q;
          end
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef MULTDIV_DIV_EN
    dz_d   = (state_q == DIV) && (cnt_q == 6'd0) && dzp_q;
`endif
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULTDIV_DIV_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dzp_q   <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MULTDIV_DIV_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dzp_q   <= dzp_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef MULTDIV_DIV_EN
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results,
// a monitor pops and compares whenever done is presented.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;
  exp_t e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compare every done against the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset) begin
      chk("dz_only_with_done", div_zero & ~done, 1'b0);
      if (done) begin
        n_done++;
        chk("done_one_cycle", prev_done, 1'b0);
        chk("busy_in_done", busy, 1'b1);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_zero", div_zero, e.dz);
          chk("done_cycle", cyc, e.at);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic sm, input logic sd, input logic [31:0] av,
                       input logic [31:0] bv, input logic push,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input int lat);
    exp_t x;
    @(negedge clk);
    a = av;
    b = bv;
    start_mult = sm;
    start_div  = sd;
    if (push) begin
      x.hi = eh;
      x.lo = el;
      x.dz = ed;
      x.at = cyc + 1 + lat;
      sb_q.push_back(x);
    end
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
  endtask

  task automatic wait_idle(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      if (sb_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    if (i == max) begin
      chk("wait_timeout", 1'b1, 1'b0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic sm, input logic sd, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] eh,
                     input logic [31:0] el, input logic ed, input int lat);
    issue(sm, sd, av, bv, 1'b1, eh, el, ed, lat);
    wait_idle(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 7 * -3 = -21, with busy traced over the whole operation
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
    for (int k = 0; k < 34; k++) begin
      chk("busy_run", busy, 1'b1);
      @(negedge clk);
    end
    chk("busy_clear", busy, 1'b0);
    wait_idle(60);

    run(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33);
    run(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33);
    run(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0, 33);
    run(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33);
    run(1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0, 33);
    // Both starts together: multiply 6 * -2 = -12
    run(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 33);

`ifdef MULTDIV_DIV_EN
    run(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33);
    run(1'b0, 1'b1, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, 33);
    run(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33);
    // Preload 3 * 5 = 15, then divide by zero leaves HI/LO untouched
    run(1'b1, 1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0, 33);
    run(1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0000, 32'h0000_000F, 1'b1, 1);
    chk("dz_hold_lo", lo, 32'h0000_000F);
`else
    // Divider absent: start_div is ignored entirely
    n0 = n_done;
    issue(1'b0, 1'b1, 32'd5, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    chk("nodiv_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    chk("nodiv_no_done", n_done, n0);
    chk("nodiv_lo_hold", lo, 32'hFFFF_FFF4);
`endif

    // Start pulse while busy is ignored; one done with the first result
    issue(1'b1, 1'b0, 32'd9, 32'd9, 1'b1, 32'h0000_0000, 32'h0000_0051, 1'b0, 33);
    repeat (8) @(negedge clk);
    issue(1'b1, 1'b0, 32'd2, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    wait_idle(60);
    n0 = n_done;
    repeat (40) @(negedge clk);
    chk("collision_single_done", n_done, n0);

    // Reset in the middle of a multiply
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 33);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_done", done, 1'b0);
    sb_q.delete();
    n0 = n_done;
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_no_done", n_done, n0);
    chk("abort_lo_hold", lo, 32'h0);

    // Fresh multiply after the abort: 0x10000 * 0x10000 = 2^32
    run(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 33);
    repeat (3) @(negedge clk);
    chk("final_hi_hold", hi, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
